keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Input-side counterpart of the multiplexed 7-segment display driver. It strobes the columns of a passive row/column key matrix one at a time and reads back the rows. Each matrix scan is debounced, and the block reports one event per stable single-key press. Key codes are shifted into a 16-bit nibble register whose width matches the hex display's data bus, so a top level can show the last four keys typed.

Parameters:
ROWS, 4, number of matrix rows; ROWS*COLS must be ≤ 16.
COLS, 4, number of matrix columns; ≥ 2.
SCAN_DIV, 4096, clk cycles each column stays strobed (dwell); ≥ 4.
DEBOUNCE, 4, consecutive identical full scans required to accept a press or release; ≥ 1.

Ports:
clk  in  1  system clock; single clock domain.
rst_n  in  1  asynchronous active-low reset.
rows_n  in  ROWS  matrix row inputs; active low (pulled up externally); asynchronous to clk.
cols_n  out  COLS  column strobes; active low, one-hot-low.
key_code  out  4  code of the accepted key = row*COLS + col, zero-extended.
key_valid  out  1  one-cycle pulse when a press is accepted.
key_held  out  1  high from acceptance until release is debounced.
data_out  out  16  last four accepted codes; newest in [3:0].

Behaviour:
- Reset (async assert, sync release) state: col_idx=0, cols_n=~1 (column 0 driven), dwell counter 0, FSM IDLE, key_code=0, key_valid=0, key_held=0, data_out=0, synchronizers all-ones.
- rows_n passes through a 2-flop synchronizer to give rows_s; the raw input is never used.
- Dwell counter counts 0..SCAN_DIV-1. On its terminal count:
  - sample ~rows_s for the current column into the scan snapshot;
  - advance col_idx; COLS-1 wraps to 0;
  - drive cols_n for the new column on the next cycle.
- Sampling on the last dwell cycle leaves SCAN_DIV-3 cycles of settling after the strobe change.
- Scan end = terminal count of column COLS-1; full scan period = SCAN_DIV*COLS cycles.
- At scan end the snapshot is classified as exactly one of:
  - NONE: no bits set;
  - SINGLE: exactly one bit set, with code;
  - MULTI: two or more bits set.
- FSM is evaluated only on scan-end cycles. Stability counter cnt counts 0..DEBOUNCE.
  - IDLE: SINGLE(c) → DEB_PRESS with cand=c, cnt=1. NONE or MULTI → stay.
  - DEB_PRESS:
    - SINGLE(cand) → cnt+1;
    - SINGLE(other) → cand=new code, cnt=1;
    - NONE or MULTI → IDLE;
    - when cnt reaches DEBOUNCE → PRESSED. In that same scan-end cycle, register key_code=cand, data_out={data_out[11:0],cand}, key_held=1. key_valid is high for exactly the following cycle.
    - With DEBOUNCE=1, acceptance happens on the first SINGLE scan.
  - PRESSED: any non-NONE snapshot (same key, a second key, MULTI) → stay, with no new event. NONE → DEB_REL, cnt=1.
  - DEB_REL:
    - NONE → cnt+1;
    - any non-NONE → PRESSED;
    - when cnt reaches DEBOUNCE → IDLE and key_held=0 (registered at that scan end).
- Rollover is not supported: a second key pressed while one is held never produces an event. After all keys are released, a fresh press is required.
- key_code holds its value until the next acceptance.
- Reset mid-scan or mid-debounce: everything returns to reset values immediately and no key_valid is issued.
- Latency from a stable press (already synchronized) to key_valid: between (DEBOUNCE-1)*SCAN_DIV*COLS+1 and DEBOUNCE*SCAN_DIV*COLS+1 cycles, plus 2 synchronizer cycles.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, DEB_PRESS, PRESSED, DEB_REL);
  - snapshot class encoding (NONE, SINGLE, MULTI);
  - the key-code width constant (4).
- One natural sub-module: keypad_strobe. It contains the dwell counter and column ring, and outputs cols_n, col_idx, a sample_en pulse and a scan_end pulse.
- Classification and the FSM stay in the top module.

Test Plan:
(Bench uses SCAN_DIV=4, COLS=4, ROWS=4, DEBOUNCE=2, giving a 16-cycle scan. The bench models the matrix by pulling rows_n low when the key's column is strobed.)
- Reset: hold rst_n=0 mid-run → cols_n=4'b1110, key_valid=0, key_held=0, data_out=16'h0000. After release, cols_n sequence is 1110, 1101, 1011, 0111, each for 4 cycles.
- Single press: hold key row 2 / col 1 steady → exactly one key_valid pulse, key_code=4'h9, data_out=16'h0009, key_held=1. Release → key_held drops after 2 NONE scans; no further pulses.
- Bounce: toggle key 5 every 8 cycles for 100 cycles, then hold steady → no pulse during bouncing; exactly one pulse after 2 clean scans.
- Sequence: press/release keys 1, 2, 3, A, then F → data_out=16'h123A, then 16'h23AF, with exactly 5 key_valid pulses.
- Ghost/rollover: press keys 0 and 5 together from IDLE → no event. Hold key 3 until accepted, then add key 7 → no second event. Release both → IDLE.
- Async reset during DEB_PRESS (after 1 matching scan) → no pulse, data_out remains 0. After reset, a continuing steady press is accepted normally.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
//============================================================================
// Module      : keypad_scanner_pkg
// Description : Shared encodings for the key-matrix scanner.
// Revision    : 1.0 - initial release
//============================================================================
package keypad_scanner_pkg;

    localparam int c_key_w  = 4;
    localparam int c_data_w = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_DEB_REL   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SNAP_NONE   = 2'd0,
        SNAP_SINGLE = 2'd1,
        SNAP_MULTI  = 2'd2
    } snap_class_t;

endpackage

`default_nettype wire

// File: rtl/keypad_strobe.sv
`default_nettype none
//============================================================================
// Module      : keypad_strobe
// Description : Column dwell counter and one-hot-low column ring.
// Revision    : 1.0 - initial release
//============================================================================
module keypad_strobe #(
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [COLS-1:0]           cols_n,
    output logic [$clog2(COLS)-1:0]   col_idx,
    output logic                      sample_en,
    output logic                      scan_end
);

    localparam int c_dw = $clog2(SCAN_DIV);
    localparam int c_cw = $clog2(COLS);

    logic [c_dw-1:0] r_dwell;
    logic [c_cw-1:0] w_col_next;

    assign sample_en  = (r_dwell == c_dw'(SCAN_DIV - 1));
    assign scan_end   = sample_en && (col_idx == c_cw'(COLS - 1));
    assign w_col_next = (col_idx == c_cw'(COLS - 1)) ? '0 : col_idx + c_cw'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell <= '0;
            col_idx <= '0;
            cols_n  <= {{(COLS-1){1'b1}}, 1'b0};
        end else if (sample_en) begin
            r_dwell <= '0;
            col_idx <= w_col_next;
            cols_n  <= ~(COLS'(1) << w_col_next);
        end else begin
            r_dwell <= r_dwell + c_dw'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
//============================================================================
// Module      : keypad_scanner
// Description : Scans a row/column key matrix, debounces, and reports presses.
// Revision    : 1.0 - initial release
//============================================================================
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 4096,
    parameter int DEBOUNCE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS-1:0]      rows_n,
    output logic [COLS-1:0]      cols_n,
    output logic [c_key_w-1:0]   key_code,
    output logic                 key_valid,
    output logic                 key_held,
    output logic [c_data_w-1:0]  data_out
);

    localparam int c_nk    = ROWS * COLS;
    localparam int c_cnt_w = $clog2(DEBOUNCE + 1);

    logic [$clog2(COLS)-1:0] w_col_idx;
    logic                    w_sample_en;
    logic                    w_scan_end;
    logic [ROWS-1:0]         r_sync1;
    logic [ROWS-1:0]         r_rows_s;
    logic [c_nk-1:0]         r_snap;
    logic [c_nk-1:0]         w_snap;
    logic [4:0]              w_ones;
    logic [c_key_w-1:0]      w_code;
    snap_class_t             w_class;
    state_t                  r_state, w_state_nxt;
    logic [c_key_w-1:0]      r_cand, w_cand_nxt;
    logic [c_cnt_w-1:0]      r_cnt, w_cnt_nxt;
    logic                    w_accept;
    logic                    w_release;

    keypad_strobe #(
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_strobe (
        .clk       (clk),
        .rst_n     (rst_n),
        .cols_n    (cols_n),
        .col_idx   (w_col_idx),
        .sample_en (w_sample_en),
        .scan_end  (w_scan_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '1;
            r_rows_s <= '1;
            r_snap   <= '0;
        end else begin
            r_sync1  <= rows_n;
            r_rows_s <= r_sync1;
            if (w_sample_en)
                r_snap <= w_snap;
        end
    end

    // The column being sampled this cycle is merged in so scan-end sees the full matrix.
    always_comb begin
        w_snap = r_snap;
        for (int r = 0; r < ROWS; r++)
            w_snap[r*COLS + int'(w_col_idx)] = ~r_rows_s[r];
    end

    always_comb begin
        w_ones = '0;
        w_code = '0;
        for (int i = 0; i < c_nk; i++) begin
            if (w_snap[i]) begin
                w_ones = w_ones + 5'd1;
                w_code = c_key_w'(i);
            end
        end
        if (w_ones == 5'd0)
            w_class = SNAP_NONE;
        else if (w_ones == 5'd1)
            w_class = SNAP_SINGLE;
        else
            w_class = SNAP_MULTI;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        if (w_scan_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_class == SNAP_SINGLE) begin
                        w_cand_nxt = w_code;
                        if (DEBOUNCE == 1) begin
                            w_state_nxt = ST_PRESSED;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_DEB_PRESS;
                            w_cnt_nxt   = c_cnt_w'(1);
                        end
                    end
                end
                ST_DEB_PRESS: begin
                    if (w_class != SNAP_SINGLE) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_code != r_cand) begin
                        w_cand_nxt = w_code;
                        w_cnt_nxt  = c_cnt_w'(1);
                    end else if (int'(r_cnt) + 1 >= DEBOUNCE) begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                ST_PRESSED: begin
                    if (w_class == SNAP_NONE) begin
                        if (DEBOUNCE == 1) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_DEB_REL;
                            w_cnt_nxt   = c_cnt_w'(1);
                        end
                    end
                end
                ST_DEB_REL: begin
                    if (w_class != SNAP_NONE) begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (int'(r_cnt) + 1 >= DEBOUNCE) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // DEB_REL -> PRESSED is a bounce on release, not a new press.
    always_comb begin
        w_accept  = (w_state_nxt == ST_PRESSED) &&
                    ((r_state == ST_IDLE) || (r_state == ST_DEB_PRESS));
        w_release = (w_state_nxt == ST_IDLE) &&
                    ((r_state == ST_PRESSED) || (r_state == ST_DEB_REL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            data_out  <= '0;
        end else begin
            key_valid <= w_accept;
            if (w_accept) begin
                key_code <= w_cand_nxt;
                data_out <= {data_out[c_data_w-c_key_w-1:0], w_cand_nxt};
                key_held <= 1'b1;
            end else if (w_release) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
//============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner with a key-matrix model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows_n;
    logic [3:0]  cols_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] data_out;
    logic [15:0] pressed = '0;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] data;
    } vec_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pulses = 0;
    logic prev_valid = 1'b0;

    keypad_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rows_n    (rows_n),
        .cols_n    (cols_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    // A held key shorts its row to its column while that column is strobed.
    always_comb begin
        rows_n = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (pressed[r*COLS + c] && !cols_n[c])
                    rows_n[r] = 1'b0;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && key_valid) begin
            pulses++;
            check("key_valid one-cycle", 16'(prev_valid), 16'd0);
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected key_valid: code %h data %h, expected no event", key_code, data_out);
            end else begin
                e = sb_q.pop_front();
                check("key_code", 16'(key_code), 16'(e.code));
                check("data_out", data_out, e.data);
                check("key_held at pulse", 16'(key_held), 16'd1);
            end
        end
        prev_valid = rst_n && key_valid;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 16'(sb_q.size()), 16'd0);
        sb_q.delete();
    endtask

    task automatic press_key(input logic [3:0] code, input logic [15:0] exp_d);
        sb_q.push_back({code, exp_d});
        pressed[code] = 1'b1;
        wait_drain("press accepted in time", 80);
    endtask

    task automatic release_all();
        pressed = '0;
        cycles(8);
        check("key_held before release debounce", 16'(key_held), 16'd1);
        cycles(40);
        check("key_held after release", 16'(key_held), 16'd0);
    endtask

    // Lands at the first cycle that column 0 is strobed.
    task automatic align_scan();
        int n = 0;
        while (cols_n == 4'b1110 && n < 64) begin cycles(1); n++; end
        while (cols_n != 4'b1110 && n < 64) begin cycles(1); n++; end
        check("scan alignment found", 16'(cols_n), 16'h000e);
    endtask

    initial begin
        logic [3:0] col_seq [4];
        vec_t       seq_tbl [5];
        int         p0;

        col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seq_tbl = '{'{4'h1, 16'h0951}, '{4'h2, 16'h9512}, '{4'h3, 16'h5123},
                    '{4'hA, 16'h123A}, '{4'hF, 16'h23AF}};

        // Reset state and column sequence
        cycles(3);
        check("reset cols_n", 16'(cols_n), 16'h000e);
        check("reset data_out", data_out, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("cols_n sequence", 16'(cols_n), 16'(col_seq[i/4]));
            cycles(1);
        end
        cycles(6);
        #2 rst_n = 1'b0;
        #1;
        check("mid-run reset cols_n", 16'(cols_n), 16'h000e);
        check("mid-run reset key_valid", 16'(key_valid), 16'd0);
        check("mid-run reset key_held", 16'(key_held), 16'd0);
        cycles(2);
        rst_n = 1'b1;

        // Single press: row 2 / col 1
        press_key(4'h9, 16'h0009);
        cycles(16);
        check("held key_code", 16'(key_code), 16'h0009);
        check("held key_held", 16'(key_held), 16'd1);
        release_all();

        // Bounce: first a fast chatter, then one-scan-on/one-scan-off
        p0 = pulses;
        align_scan();
        for (int i = 0; i < 13; i++) begin
            pressed[5] = (i % 2 == 1);
            cycles(8);
        end
        align_scan();
        for (int i = 0; i < 6; i++) begin
            pressed[5] = (i % 2 == 0);
            cycles(16);
        end
        check("no pulse while bouncing", 16'(pulses - p0), 16'd0);
        press_key(4'h5, 16'h0095);
        check("one pulse after bounce", 16'(pulses - p0), 16'd1);
        release_all();

        // Key sequence table
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            press_key(seq_tbl[i].code, seq_tbl[i].data);
            release_all();
        end
        check("sequence pulse count", 16'(pulses - p0), 16'd5);
        check("sequence data_out", data_out, 16'h23AF);

        // Ghosting and rollover
        p0 = pulses;
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        cycles(80);
        check("two keys from idle: no hold", 16'(key_held), 16'd0);
        check("two keys from idle: no pulse", 16'(pulses - p0), 16'd0);
        pressed = '0;
        cycles(48);
        press_key(4'h3, 16'h3AF3);
        pressed[7] = 1'b1;
        cycles(80);
        check("rollover key_held", 16'(key_held), 16'd1);
        check("rollover key_code", 16'(key_code), 16'h0003);
        check("rollover pulse count", 16'(pulses - p0), 16'd1);
        release_all();
        press_key(4'h7, 16'hAF37);
        release_all();

        // Async reset after one matching scan of a press
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        pressed[6] = 1'b1;
        p0 = pulses;
        cycles(24);
        #2 rst_n = 1'b0;
        #1;
        check("reset in debounce data_out", data_out, 16'h0000);
        check("reset in debounce key_held", 16'(key_held), 16'd0);
        cycles(3);
        check("reset in debounce no pulse", 16'(pulses - p0), 16'd0);
        rst_n = 1'b1;
        press_key(4'h6, 16'h0006);
        release_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
